// File: rtl/ethmclk_pkg.sv
// Shared types and default constants for the recovered-clock PLL sequencer.
package ethmclk_pkg;

  typedef enum logic [1:0] {
    StHold,
    StWaitLock,
    StSettle,
    StRun
  } state_e;

  localparam int unsigned DefRstCycles    = 16;
  localparam int unsigned DefLockTimeout  = 4000;
  localparam int unsigned DefSettleCycles = 1024;
  localparam int unsigned DefActTimeout   = 64;
  localparam int unsigned DefCntW         = 8;
  localparam int unsigned TimerW          = 32;

endpackage

// File: rtl/ethmclk_sync.sv
// N-flop single-bit synchronizer; exposes the last two stages for edge detection.
module ethmclk_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic q_prev_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o      = sync_q[N-1];
  assign q_prev_o = sync_q[N-2];

endmodule

// File: rtl/ethmclk_ctrl.sv
// PLL reset sequencer and lock qualifier for the Ethernet-recovered clock.
// Define ETHMCLK_ACT_EN to build the RX clock activity watchdog.
module ethmclk_ctrl
  import ethmclk_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DefRstCycles,
  parameter int unsigned LOCK_TIMEOUT  = DefLockTimeout,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned ACT_TIMEOUT   = DefActTimeout,
  parameter int unsigned CNT_W         = DefCntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pll_locked_i,
  input  logic             rxclk_toggle_i,
  output logic             pll_rst_o,
  output logic             clk_ok_o,
  output logic             lock_timeout_o,
  output logic [CNT_W-1:0] relock_cnt_o
);

  logic locked_s;
  logic unused_lock_prev;
  logic act_ok;

  ethmclk_sync #(
    .N(2)
  ) u_sync_lock (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (pll_locked_i),
    .q_o     (locked_s),
    .q_prev_o(unused_lock_prev)
  );

`ifdef ETHMCLK_ACT_EN
  localparam int unsigned ActW = $clog2(ACT_TIMEOUT + 1);
  localparam logic [ActW-1:0] ActMax = ActW'(ACT_TIMEOUT);

  logic tog_s2, tog_s3;
  logic act_edge;
  logic [ActW-1:0] act_cnt_q;

  ethmclk_sync #(
    .N(3)
  ) u_sync_tog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (rxclk_toggle_i),
    .q_o     (tog_s3),
    .q_prev_o(tog_s2)
  );

  assign act_edge = tog_s2 ^ tog_s3;

  // Resets to the timeout value so the RX clock is untrusted until it toggles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_cnt_q <= ActMax;
    end else if (act_edge) begin
      act_cnt_q <= '0;
    end else if (act_cnt_q != ActMax) begin
      act_cnt_q <= act_cnt_q + ActW'(1);
    end
  end

  assign act_ok = (act_cnt_q < ActMax);
`else
  localparam int unsigned UnusedActTimeout = ACT_TIMEOUT;
  logic unused_toggle;
  assign unused_toggle = rxclk_toggle_i;
  assign act_ok        = 1'b1;
`endif

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q;
  logic               pll_rst_q, clk_ok_q, lock_timeout_q;
  logic [CNT_W-1:0]   relock_cnt_q;
  logic               timeout_hit, relock_hit;

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    relock_hit  = 1'b0;
    case (state_q)
      StHold: begin
        if (timer_q >= TimerW'(RST_CYCLES - 1) && act_ok) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (!act_ok) begin
          state_d = StHold;
        end else if (locked_s) begin
          state_d = StSettle;
        end else if (timer_q == TimerW'(LOCK_TIMEOUT - 1)) begin
          state_d     = StHold;
          timeout_hit = 1'b1;
        end
      end
      StSettle: begin
        if (!locked_s || !act_ok) begin
          state_d = StHold;
        end else if (timer_q == TimerW'(SETTLE_CYCLES - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Simultaneous lock and activity loss still yields a single exit.
        if (!locked_s || !act_ok) begin
          state_d    = StHold;
          relock_hit = 1'b1;
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StHold;
      timer_q        <= '0;
      pll_rst_q      <= 1'b1;
      clk_ok_q       <= 1'b0;
      lock_timeout_q <= 1'b0;
      relock_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= (state_d != state_q) ? '0 : timer_q + TimerW'(1);
      pll_rst_q <= (state_d == StHold);
      clk_ok_q  <= (state_d == StRun);
      if (timeout_hit) lock_timeout_q <= 1'b1;
      if (relock_hit && relock_cnt_q != '1) relock_cnt_q <= relock_cnt_q + CNT_W'(1);
    end
  end

  assign pll_rst_o      = pll_rst_q;
  assign clk_ok_o       = clk_ok_q;
  assign lock_timeout_o = lock_timeout_q;
  assign relock_cnt_o   = relock_cnt_q;

endmodule

// File: tb/tb_ethmclk_ctrl.sv
// Directed self-checking bench for ethmclk_ctrl; activity tests build only with ETHMCLK_ACT_EN.
module tb_ethmclk_ctrl;

  localparam int unsigned RstCycles    = 4;
  localparam int unsigned LockTimeout  = 50;
  localparam int unsigned SettleCycles = 20;
  localparam int unsigned ActTimeout   = 8;
  localparam int unsigned CntW         = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pll_locked = 1'b0;
  logic            rxclk_toggle = 1'b0;
  logic            pll_rst, clk_ok, lock_timeout;
  logic [CntW-1:0] relock_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_tog_cyc = 0;
  bit tog_en = 1'b1;
  bit tog_ph = 1'b0;

  ethmclk_ctrl #(
    .RST_CYCLES   (RstCycles),
    .LOCK_TIMEOUT (LockTimeout),
    .SETTLE_CYCLES(SettleCycles),
    .ACT_TIMEOUT  (ActTimeout),
    .CNT_W        (CntW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pll_locked_i  (pll_locked),
    .rxclk_toggle_i(rxclk_toggle),
    .pll_rst_o     (pll_rst),
    .clk_ok_o      (clk_ok),
    .lock_timeout_o(lock_timeout),
    .relock_cnt_o  (relock_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RX toggle: flips every 2 cycles at #2 after the edge; parks low when disabled.
  initial forever begin
    @(posedge clk);
    #2;
    if (tog_en) begin
      tog_ph = ~tog_ph;
      if (tog_ph) begin
        rxclk_toggle = ~rxclk_toggle;
        last_tog_cyc = cyc;
      end
    end else if (rxclk_toggle) begin
      rxclk_toggle = 1'b0;
      last_tog_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_clk_ok(input logic val, input int lim, output int n);
    n = 0;
    while (clk_ok !== val && n < lim) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_pll_rst(input logic val, input int lim, output int n);
    n = 0;
    while (pll_rst !== val && n < lim) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(1);
    checks++;
    if (pll_rst !== 1'b1) begin
      failures++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst);
    end
    checks++;
    if (clk_ok !== 1'b0) begin
      failures++; $display("FAIL reset_clk_ok: got %b expected 0", clk_ok);
    end
    checks++;
    if (lock_timeout !== 1'b0) begin
      failures++; $display("FAIL reset_lock_timeout: got %b expected 0", lock_timeout);
    end
    checks++;
    if (relock_cnt !== '0) begin
      failures++; $display("FAIL reset_relock_cnt: got %0d expected 0", relock_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_bringup;
    int  n;
    logic ok22, ok23;
    wait_pll_rst(1'b0, 100, n);
    checks++;
`ifdef ETHMCLK_ACT_EN
    if (n < 4 || n >= 100) begin
      failures++; $display("FAIL bringup_rst_len: got %0d expected >=4", n);
    end
`else
    if (n != 4) begin
      failures++; $display("FAIL bringup_rst_len: got %0d expected 4", n);
    end
`endif
    tick(10);
    pll_locked = 1'b1;
    ok22 = 1'bx;
    ok23 = 1'bx;
    for (int k = 1; k <= 23; k++) begin
      tick(1);
      if (k == 22) ok22 = clk_ok;
      if (k == 23) ok23 = clk_ok;
    end
    checks++;
    if (ok22 !== 1'b0) begin
      failures++; $display("FAIL bringup_clk_ok_22: got %b expected 0", ok22);
    end
    checks++;
    if (ok23 !== 1'b1) begin
      failures++; $display("FAIL bringup_clk_ok_23: got %b expected 1", ok23);
    end
    checks++;
    if (pll_rst !== 1'b0 || relock_cnt !== 8'd0) begin
      failures++;
      $display("FAIL bringup_run: got pll_rst=%b relock=%0d expected 0/0", pll_rst, relock_cnt);
    end
  endtask

  task automatic test_relock;
    int n;
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    checks++;
    if (clk_ok !== 1'b1) begin
      failures++; $display("FAIL relock_edge2: got clk_ok=%b expected 1", clk_ok);
    end
    tick(1);
    checks++;
    if (clk_ok !== 1'b0 || pll_rst !== 1'b1) begin
      failures++;
      $display("FAIL relock_edge3: got clk_ok=%b pll_rst=%b expected 0/1", clk_ok, pll_rst);
    end
    checks++;
    if (relock_cnt !== 8'd1) begin
      failures++; $display("FAIL relock_cnt: got %0d expected 1", relock_cnt);
    end
    wait_clk_ok(1'b1, 100, n);
    checks++;
    if (n != 25) begin
      failures++; $display("FAIL relock_rerun: got %0d cycles expected 25", n);
    end
  endtask

`ifdef ETHMCLK_ACT_EN
  task automatic test_activity;
    int n;
    logic [CntW-1:0] rc0;
    rc0 = relock_cnt;
    tog_en = 1'b0;
    wait_clk_ok(1'b0, 40, n);
    checks++;
    if (clk_ok !== 1'b0 || (cyc - last_tog_cyc - 1) != 11) begin
      failures++;
      $display("FAIL act_loss_delay: got clk_ok=%b delay=%0d expected 0/11", clk_ok,
               cyc - last_tog_cyc - 1);
    end
    checks++;
    if (pll_rst !== 1'b1 || relock_cnt !== rc0 + 8'd1) begin
      failures++;
      $display("FAIL act_loss_state: got pll_rst=%b relock=%0d expected 1/%0d", pll_rst,
               relock_cnt, rc0 + 8'd1);
    end
    tog_en = 1'b1;
    wait_clk_ok(1'b1, 200, n);
    checks++;
    if (clk_ok !== 1'b1) begin
      failures++; $display("FAIL act_recover: got clk_ok=%b expected 1", clk_ok);
    end
    // Lock loss lands on the same cycle that act_ok falls.
    rc0 = relock_cnt;
    tog_en = 1'b0;
    tick(1);
    while (cyc < last_tog_cyc + 9) tick(1);
    pll_locked = 1'b0;
    wait_clk_ok(1'b0, 20, n);
    checks++;
    if (clk_ok !== 1'b0 || cyc != last_tog_cyc + 12) begin
      failures++;
      $display("FAIL dual_loss_time: got clk_ok=%b at +%0d expected 0 at +12", clk_ok,
               cyc - last_tog_cyc);
    end
    tick(5);
    checks++;
    if (relock_cnt !== rc0 + 8'd1) begin
      failures++;
      $display("FAIL dual_loss_cnt: got %0d expected %0d", relock_cnt, rc0 + 8'd1);
    end
    pll_locked = 1'b1;
    tog_en = 1'b1;
    wait_clk_ok(1'b1, 200, n);
  endtask
`endif

  task automatic test_timeout;
    int   n;
    logic pr49, lt49, pr50, lt50;
    pll_locked = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    wait_pll_rst(1'b0, 100, n);
    pr49 = 1'bx; lt49 = 1'bx; pr50 = 1'bx; lt50 = 1'bx;
    for (int k = 1; k <= 50; k++) begin
      tick(1);
      if (k == 49) begin pr49 = pll_rst; lt49 = lock_timeout; end
      if (k == 50) begin pr50 = pll_rst; lt50 = lock_timeout; end
    end
    checks++;
    if (pr49 !== 1'b0 || lt49 !== 1'b0) begin
      failures++; $display("FAIL timeout_49: got pll_rst=%b flag=%b expected 0/0", pr49, lt49);
    end
    checks++;
    if (pr50 !== 1'b1 || lt50 !== 1'b1) begin
      failures++; $display("FAIL timeout_50: got pll_rst=%b flag=%b expected 1/1", pr50, lt50);
    end
    wait_pll_rst(1'b0, 20, n);
    checks++;
    if (n != 4) begin
      failures++; $display("FAIL timeout_hold_len: got %0d expected 4", n);
    end
    wait_pll_rst(1'b1, 100, n);
    checks++;
    if (n != 50 || lock_timeout !== 1'b1 || clk_ok !== 1'b0) begin
      failures++;
      $display("FAIL timeout_retry: got n=%0d flag=%b clk_ok=%b expected 50/1/0", n,
               lock_timeout, clk_ok);
    end
  endtask

  task automatic test_saturate;
    int n;
    int stuck;
    int exp_cnt;
    stuck = 0;
    exp_cnt = 0;
    rst = 1'b1;
    pll_locked = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      wait_clk_ok(1'b1, 200, n);
      if (clk_ok !== 1'b1) stuck++;
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      wait_clk_ok(1'b0, 10, n);
      if (clk_ok !== 1'b0) stuck++;
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      if (i == 99 || i == 299) begin
        checks++;
        if (relock_cnt !== exp_cnt[CntW-1:0]) begin
          failures++;
          $display("FAIL saturate_cnt_%0d: got %0d expected %0d", i, relock_cnt, exp_cnt);
        end
      end
    end
    checks++;
    if (stuck != 0) begin
      failures++; $display("FAIL saturate_progress: got %0d stalls expected 0", stuck);
    end
  endtask

  task automatic test_rst_settle;
    int n;
    pll_locked = 1'b0;
    wait_pll_rst(1'b0, 20, n);
    wait_pll_rst(1'b1, 60, n);
    checks++;
    if (lock_timeout !== 1'b1 || relock_cnt !== 8'd255) begin
      failures++;
      $display("FAIL pre_rst_state: got flag=%b relock=%0d expected 1/255", lock_timeout,
               relock_cnt);
    end
    pll_locked = 1'b1;
    wait_pll_rst(1'b0, 20, n);
    tick(3);
    checks++;
    if (pll_rst !== 1'b0 || clk_ok !== 1'b0) begin
      failures++;
      $display("FAIL settle_state: got pll_rst=%b clk_ok=%b expected 0/0", pll_rst, clk_ok);
    end
    test_reset();
  endtask

  task automatic test_no_activity;
    int n;
    tog_en = 1'b0;
    tick(2);
    pll_locked = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
`ifdef ETHMCLK_ACT_EN
    tick(100);
    checks++;
    if (pll_rst !== 1'b1 || clk_ok !== 1'b0) begin
      failures++;
      $display("FAIL no_act_hold: got pll_rst=%b clk_ok=%b expected 1/0", pll_rst, clk_ok);
    end
`else
    wait_clk_ok(1'b1, 100, n);
    checks++;
    if (clk_ok !== 1'b1 || n != 25) begin
      failures++; $display("FAIL no_act_run: got clk_ok=%b n=%0d expected 1/25", clk_ok, n);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_relock();
`ifdef ETHMCLK_ACT_EN
    test_activity();
`endif
    test_timeout();
    test_saturate();
    test_rst_settle();
    test_no_activity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
